// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding and default sizing for the period meter
package period_meter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 4095;

endpackage

// File: rtl/sync_edge_detector.sv
// rtl/sync_edge_detector.sv - 2-flop synchronizer plus delay flop with rising-edge detect
module sync_edge_detector (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] fill;

  always_ff @(posedge clock) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end

  // Edges are only trusted once s3 holds real input data; otherwise a level that was
  // already high across reset release would look like a fresh rising edge.
  assign level = s2;
  assign rise  = s2 & ~s3 & (fill == 2'd3);

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow signal in system-clock cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;
  logic             level;
  logic             rise;

  sync_edge_detector u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (sig_in),
    .level (level),
    .rise  (rise)
  );

  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // First edge only arms the meter; there is no prior edge to measure from.
            if (rise) begin
              state <= ST_MEASURE;
              busy  <= 1'b1;
              cnt   <= ONE;
              hcnt  <= ONE;
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hcnt;
              valid     <= 1'b1;
              timeout   <= 1'b0;
              cnt       <= ONE;
              hcnt      <= ONE;
            end else if (cnt == TIMEOUT_CNT) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
              if (level) begin
                hcnt <= hcnt + ONE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
